// File: rtl/riscv_soc_pkg.sv
// Shared SoC constants: data-memory responder FSM encoding, response codes
// and the rule deciding whether a data-memory access faults.
package riscv_soc_pkg;

   localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
   localparam logic [1:0] DMEM_ST_WAIT = 2'd1;
   localparam logic [1:0] DMEM_ST_RESP = 2'd2;

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   // Misaligned byte address or word index beyond the array faults.
   function automatic logic dmem_fault(input logic [31:0] addr, input logic [31:0] depth_words);
      logic [31:0] w_idx;
      w_idx = {2'b00, addr[31:2]};
      return (addr[1:0] != 2'b00) || (w_idx >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that only updates on a read access.
module dmem_resp_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Storage is deliberately not reset; read data holds between reads.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < 4; b++) begin
               if (i_be[b]) begin
                  r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
               end
            end
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request in, one outstanding access,
// WAIT_CYCLES wait states, response held until the initiator takes it.
module dmem_resp
   import riscv_soc_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic        r_rd_ok;

   logic        w_accept;
   logic        w_access;
   logic        w_fault;
   logic        w_acc_we;
   logic [31:0] w_acc_addr;
   logic [31:0] w_acc_wdata;
   logic [3:0]  w_acc_be;
   logic [31:0] w_ram_rdata;

   // rst_n gating keeps a zero-wait build from touching the RAM during reset.
   assign w_accept = req_valid_i & r_req_ready & rst_n;

   // The access happens on the edge entering RESP: live request when there are no wait states.
   always_comb begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
      w_access    = 1'b0;
      if (r_state == DMEM_ST_IDLE) begin
         w_acc_we    = req_we_i;
         w_acc_addr  = req_addr_i;
         w_acc_wdata = req_wdata_i;
         w_acc_be    = req_be_i;
         w_access    = (WAIT_CYCLES == 32'd0) ? w_accept : 1'b0;
      end else if (r_state == DMEM_ST_WAIT) begin
         w_access = (r_cnt == 4'd0);
      end else begin
         w_access = 1'b0;
      end
   end

   assign w_fault = dmem_fault(w_acc_addr, DEPTH_WORDS);

   dmem_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_access & ~w_fault),
      .i_we    (w_acc_we),
      .i_be    (w_acc_be),
      .i_addr  (w_acc_addr[AW+1:2]),
      .i_wdata (w_acc_wdata),
      .o_rdata (w_ram_rdata)
   );

   // Transaction FSM, request latch and registered response flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DMEM_ST_IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= RSP_OK;
         r_rd_ok     <= 1'b0;
      end else begin
         case (r_state)
            DMEM_ST_IDLE: begin
               if (w_accept) begin
                  r_we        <= req_we_i;
                  r_addr      <= req_addr_i;
                  r_wdata     <= req_wdata_i;
                  r_be        <= req_be_i;
                  r_req_ready <= 1'b0;
                  if (WAIT_CYCLES == 32'd0) begin
                     r_state <= DMEM_ST_RESP;
                  end else begin
                     r_state <= DMEM_ST_WAIT;
                     r_cnt   <= CNT_LOAD;
                  end
               end
            end
            DMEM_ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= DMEM_ST_RESP;
               end
            end
            DMEM_ST_RESP: begin
               if (rsp_ready_i) begin
                  r_state     <= DMEM_ST_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= RSP_OK;
                  r_rd_ok     <= 1'b0;
               end
            end
            default: begin
               r_state     <= DMEM_ST_IDLE;
               r_cnt       <= 4'd0;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= RSP_OK;
               r_rd_ok     <= 1'b0;
            end
         endcase
         if (w_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_fault ? RSP_ERR : RSP_OK;
            r_rd_ok     <= ~w_fault & ~w_acc_we;
         end
      end
   end

   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_rdata_o = r_rd_ok ? w_ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table and corner sequences
// on a one-wait-state and a zero-wait-state instance, then randomized traffic.
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_ready [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic        rsp_err   [2];
   logic [31:0] rsp_rdata [2];

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] model [2][16];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
      .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
   );

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference behaviour: faults leave memory alone, stores merge lanes, loads read the word.
   function automatic void ref_access(input int s, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] rdata, output logic err);
      int unsigned idx;
      idx   = addr / 4;
      rdata = 32'd0;
      err   = 1'b0;
      if ((addr % 4) != 0 || idx >= 1024) begin
         err = 1'b1;
      end else if (we) begin
         for (int n = 0; n < 4; n++)
            if (be[n]) model[s][idx][8*n +: 8] = wdata[8*n +: 8];
      end else begin
         rdata = model[s][idx];
      end
   endfunction

   task automatic txn(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
      logic acc;
      acc = 1'b0; lat = 0; rdata = 32'd0; err = 1'b0;
      @(negedge clk);
      req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
      req_wdata[s] = wdata; req_be[s] = be; rsp_ready[s] = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         if (req_ready[s]) begin
            @(posedge clk);
            acc = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      #1;
      req_valid[s] = 1'b0;
      chk("accept", {62'd0, acc, req_ready[s]}, 64'd2);
      if (acc) begin
         lat = 1;
         while (!rsp_valid[s] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("rsp_seen", {63'd0, rsp_valid[s]}, 64'd1);
         rdata = rsp_rdata[s];
         err   = rsp_err[s];
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("rsp_hold", {29'd0, rsp_valid[s], req_ready[s], rsp_err[s], rsp_rdata[s]},
                {29'd0, 1'b1, 1'b0, err, rdata});
         end
         @(negedge clk);
         rsp_ready[s] = 1'b1;
         @(posedge clk); #1;
         rsp_ready[s] = 1'b0;
         chk("rsp_done", {62'd0, rsp_valid[s], req_ready[s]}, 64'd1);
      end
   endtask

   initial begin
      logic [31:0] rd, erd, addr, wdata;
      logic        er, eer, we, rdy_pre;
      logic [3:0]  be;
      int          lat, k, last_acc, s;
      int unsigned r, idx;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'd0;
         req_wdata[i] = 32'd0; req_be[i] = 4'd0; rsp_ready[i] = 1'b0;
      end

      vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b0, 32'h22,   32'h0,        4'h0, 32'h0,        1'b1};
      vecs[6]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h22,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[9]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[10] = '{1'b1, 32'h10,   32'h12345678, 4'h0, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[12] = '{1'b1, 32'h30,   32'h0,        4'hF, 32'h0,        1'b0};
      vecs[13] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[15] = '{1'b0, 32'hFFF,  32'h0,        4'h0, 32'h0,        1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_dut%0d", i), {29'd0, req_ready[i], rsp_valid[i], rsp_err[i], rsp_rdata[i]},
             {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
      // Release between edges so the first request meets the first rising edge.
      @(posedge clk); #2;
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         txn(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 3, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
         chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      end

      // Stalled response with a second request already pending.
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_be[1] = 4'h0; rsp_ready[1] = 1'b0;
      @(posedge clk); #1;
      chk("stall_accept1", {63'd0, req_ready[1]}, 64'd0);
      req_addr[1] = 32'h20;
      @(posedge clk); #1;
      chk("stall_rsp", {30'd0, rsp_valid[1], req_ready[1], rsp_rdata[1]}, {30'd0, 1'b1, 1'b0, 32'hDEADBEEF});
      for (int h = 0; h < 5; h++) begin
         @(posedge clk); #1;
         chk("stall_hold", {29'd0, rsp_valid[1], req_ready[1], rsp_err[1], rsp_rdata[1]},
             {29'd0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
      end
      @(negedge clk); rsp_ready[1] = 1'b1;
      @(posedge clk); #1; rsp_ready[1] = 1'b0;
      chk("stall_done", {62'd0, rsp_valid[1], req_ready[1]}, 64'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      chk("stall_accept2", {62'd0, rsp_valid[1], req_ready[1]}, 64'd0);
      @(posedge clk); #1;
      chk("stall_rsp2", {31'd0, rsp_valid[1], rsp_rdata[1]}, {31'd0, 1'b1, 32'h11BB33DD});
      @(negedge clk); rsp_ready[1] = 1'b1;
      @(posedge clk); #1; rsp_ready[1] = 1'b0;

      // Reset during the wait state of a store must drop the write.
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h30;
      req_wdata[1] = 32'h55555555; req_be[1] = 4'hF;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      chk("abort_in_wait", {62'd0, req_ready[1], rsp_valid[1]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_reset", {29'd0, req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      txn(1, 1'b0, 32'h30, 32'd0, 4'h0, 0, rd, er, lat);
      chk("abort_load", {31'd0, er, rd}, 64'd0);

      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 16; w++) begin
            wdata = $urandom;
            ref_access(i, 1'b1, 32'(w * 4), wdata, 4'hF, erd, eer);
            txn(i, 1'b1, 32'(w * 4), wdata, 4'hF, 0, rd, er, lat);
            chk("preload", {31'd0, er, rd}, 64'd0);
         end

      // Zero-wait back-to-back loads with the response always taken.
      @(negedge clk);
      rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd0;
      k = 0; last_acc = -2;
      for (int c = 0; c < 10; c++) begin
         rdy_pre = req_ready[0];
         @(posedge clk); #1;
         if (rdy_pre) begin
            chk("b2b_spacing", 64'(c - last_acc), 64'd2);
            last_acc = c;
            chk("b2b_rsp", {31'd0, rsp_valid[0], rsp_rdata[0]}, {31'd0, 1'b1, model[0][k % 4]});
            k++;
            req_addr[0] = 32'((k % 4) * 4);
         end else begin
            chk("b2b_idle", {63'd0, rsp_valid[0]}, 64'd0);
         end
      end
      chk("b2b_count", 64'(k), 64'd5);
      req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;

      for (int t = 0; t < 80; t++) begin
         s     = int'($urandom_range(0, 1));
         r     = $urandom_range(0, 9);
         idx   = $urandom_range(0, 15);
         we    = 1'($urandom_range(0, 1));
         be    = 4'($urandom_range(0, 15));
         wdata = $urandom;
         if (r == 0) addr = 32'(idx * 4 + $urandom_range(1, 3));
         else if (r == 1) addr = 32'((1024 + $urandom_range(0, 2000)) * 4);
         else addr = 32'(idx * 4);
         ref_access(s, we, addr, wdata, be, erd, eer);
         txn(s, we, addr, wdata, be, int'($urandom_range(0, 3)), rd, er, lat);
         chk($sformatf("rnd%0d_rdata", t), {32'd0, rd}, {32'd0, erd});
         chk($sformatf("rnd%0d_err", t), {63'd0, er}, {63'd0, eer});
         chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(s + 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, storage size in 32-bit words; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, wait states between request accept and response; range 0..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req_valid_i  input  1  initiator presents a request.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data.
REQ-010 req_be_i  input  4  byte enables for stores; bit n enables byte lane n (bits 8n+7:8n); ignored for loads.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  initiator accepts the response.
REQ-013 rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err_o  output  1  the access faulted; qualified by rsp_valid_o.

Function
REQ-015 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-016 The block shall assert req_ready_o only in IDLE, and shall never gate it on req_valid_i.
REQ-017 Handshake: a request is accepted at a rising edge where req_valid_i and req_ready_o are both 1; the block shall latch we, addr, wdata and be at that edge.
REQ-018 On accept with WAIT_CYCLES>0, the FSM shall go IDLE->WAIT and load the wait counter with WAIT_CYCLES-1.
REQ-019 In WAIT, the counter shall decrement each cycle; when it reaches 0, the block shall perform the access and go WAIT->RESP on the next edge.
REQ-020 On accept with WAIT_CYCLES=0, the FSM shall go IDLE->RESP directly; rsp_valid_o shall be 1 in the cycle after accept.
REQ-021 Latency: rsp_valid_o shall first be 1 exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-022 The block shall hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until an edge where rsp_ready_i=1; at that edge the FSM shall go RESP->IDLE.
REQ-023 Only one transaction shall be outstanding; no new request is accepted in the cycle the response completes (req_ready_o=0 in RESP).
REQ-024 Error: an access with latched addr[1:0]!=0, or word index addr[31:2]>=DEPTH_WORDS, shall respond rsp_err_o=1 and rsp_rdata_o=0, and shall not modify storage.
REQ-025 A valid store shall write only the enabled byte lanes of word addr[31:2]; disabled lanes shall keep their old values.
REQ-026 A store with be=0000 shall be a legal no-op and respond with rsp_err_o=0.
REQ-027 A valid load shall return the full 32-bit word at addr[31:2], as stored before this transaction.
REQ-028 A store response shall have rsp_rdata_o=0.
REQ-029 Storage shall not be cleared by reset; contents are undefined until written.
REQ-030 rsp_valid_o shall be 0 in IDLE and WAIT.

Reset
REQ-031 While rst_n=0 the block shall be in IDLE with req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and the wait counter at 0.
REQ-032 Reset asserted in WAIT or RESP shall abort the transaction; a store that has not yet been performed shall not be written.
REQ-033 The first request shall be acceptable at the first rising edge after rst_n deasserts.

Structure
REQ-034 The FSM state encoding and the response error code constants shall live in the shared package riscv_soc_pkg.
REQ-035 Storage shall be a sub-module dmem_resp_ram: synchronous, one port, byte-write-enabled, DEPTH_WORDS x 32.
REQ-036 The wait counter shall be 4 bits wide.

Verification
REQ-037 Reset, then WAIT_CYCLES=1: store addr=0x10, wdata=0xDEADBEEF, be=1111, then load addr=0x10 -> the load returns 0xDEADBEEF with err=0, and rsp_valid_o rises 2 cycles after each accept.
REQ-038 Store 0x11223344 to addr=0x20, then store 0xAABBCCDD with be=0101, then load -> the load returns 0x11BB33DD.
REQ-039 Load addr=0x22 (misaligned), and separately load addr=DEPTH_WORDS*4 -> err=1, rdata=0, and storage is unchanged when checked by a later load.
REQ-040 Hold rsp_ready_i=0 for 5 cycles in RESP while driving req_valid_i=1 -> the response stays stable, req_ready_o=0, and the second request is accepted only after the response handshake completes.
REQ-041 With WAIT_CYCLES=0, back-to-back loads with rsp_ready_i tied high -> one accept every 2 cycles and rsp_valid_o one cycle after each accept.
REQ-042 Assert rst_n=0 during WAIT of a store to addr=0x30 (word previously 0x0) -> the outputs reset immediately, and a later load of 0x30 returns 0x0.
